mem_unit: RTL and testbench
===========================

# mem_unit

Memory-side datapath stage driven by the microcoded control unit. Holds the 16-bit program counter, the 8-bit stack pointer, the two memory-address-register bytes and the 16-bit instruction register, and arbitrates a single-port, asynchronous-read byte RAM. The opcode byte of the instruction register feeds the control unit. All control inputs are active-low strobes, except where noted, generated on the falling clock edge. This block samples them on the rising edge.

## Interface
- No parameters. Address width is fixed at 16, data width at 8, and the stack page is fixed at 0xFF.
- i_clk  in  1  system clock; all state updates on the rising edge
- i_reset  in  1  reset: synchronous, active-high
- i_hlt  in  1  high: freeze all registers and force o_ramWE=0
- i_ctrlPCIncrN  in  1  low: PC+1
- i_ctrlPCLoadN  in  1  low: PC <= {MAR1,MAR0}
- i_ctrlSPUp  in  1  stack direction: 1 = pop, 0 = push
- i_ctrlSPNEn  in  1  low: stack access this cycle
- i_ctrlInstrNWE  in  1  low: shift RAM byte into IR
- i_ctrlInstrNOE  in  1  low: drive IR immediate byte onto bus
- i_ctrlMar0NWE / i_ctrlMar1NWE  in  1 each  low: load MAR0 / MAR1 from i_bus
- i_ctrlInstrImmToRam  in  1  high: RAM write data = IR immediate byte instead of i_bus
- i_ctrlRamNWE  in  1  low: RAM write this cycle
- i_ctrlRamNOE  in  1  low: drive RAM read data onto bus
- i_bus  in  8  shared data bus value
- o_bus  out  8  data this block drives
- o_busOE  out  1  o_bus valid, driven by this block
- o_busConflict  out  1  sticky: InstrNOE and RamNOE both low in the same cycle
- o_instrCode  out  8  IR[15:8], to the control unit
- o_pc  out  16  current PC (debug)
- o_ramAddr  out  16  RAM address
- o_ramWData  out  8  RAM write data
- o_ramWE  out  1  RAM write enable; RAM captures the write on the rising edge
- i_ramRData  in  8  RAM asynchronous read data

## Operation
- Address mux, combinational, in priority order:
  - SPNEn low: address is 0xFF00 | (SPUp ? SP+1 : SP), with 8-bit wrap.
  - Else, RamNWE low or RamNOE low: address is {MAR1,MAR0}.
  - Else: address is PC (fetch).
- PC:
  - LoadN low: PC <= {MAR1,MAR0}.
  - Else, IncrN low: PC <= PC+1, wrapping 0xFFFF→0x0000.
  - Load wins if both are low.
- SP, on SPNEn low:
  - SPUp=0 (push): access at SP, then SP <= SP-1.
  - SPUp=1 (pop): access at SP+1, then SP <= SP+1.
  - 0x00−1 wraps to 0xFF.
- MAR0/MAR1: each loads i_bus independently; both may load in the same cycle.
- IR: on InstrNWE low, IR <= {IR[7:0], i_ramRData}. A two-cycle fetch leaves the opcode in [15:8] and the immediate in [7:0].
- RAM write: RamNWE low asserts o_ramWE for the cycle. o_ramWData = ImmToRam ? IR[7:0] : i_bus.
- Bus drive priority:
  - RamNWE low: o_busOE=0, and a simultaneous RamNOE is ignored.
  - Else, RamNOE low: o_bus = i_ramRData.
  - Else, InstrNOE low: o_bus = IR[7:0].
  - Else: o_busOE=0 and o_bus=0x00.
- o_busConflict: sets when RamNOE and InstrNOE are both low. It clears only on reset. RAM data wins the bus.
- i_hlt high: PC, SP, MAR and IR hold, and o_ramWE=0. Bus reads still drive.

## Timing
- Reset values, applied on the first rising edge with i_reset high:
  - PC=0x0000, SP=0xFF, MAR=0x0000, IR=0x0000, so o_instrCode=0x00.
  - o_busConflict=0.
- While i_reset is high: o_ramWE=0 and o_busOE=0. Reset overrides i_hlt and all strobes.
- Register updates are visible one rising edge after the strobe is sampled low.
- The address mux, o_bus, o_busOE and o_ramWE are combinational from the strobes and from current register values. They are valid within the same cycle.
- SP and PC address values are pre-update: a push writes to the old SP.
- Reset asserted mid-instruction aborts any write in that cycle and clears the state above on that edge.

## Test plan
- Reset, then two InstrNWE cycles with RAM[0]=0x3A and RAM[1]=0x7C, and IncrN low on both -> o_instrCode=0x3A, IR[7:0]=0x7C, PC=0x0002.
- MAR0=0x34 and MAR1=0x12 via the bus, then PCLoadN and PCIncrN both low -> PC=0x1234. Next, PC=0xFFFF with IncrN low -> PC=0x0000.
- Push with SP=0xFF, i_bus=0x55 -> o_ramAddr=0xFFFF, o_ramWE=1, SP=0xFE. Then pop -> o_ramAddr=0xFFFF, o_bus=0x55 with o_busOE=1, SP=0xFF.
- SP=0x00 push -> address 0xFF00, SP=0xFF. Then pop -> address 0xFF00, SP=0x00.
- IR[7:0]=0x9E with ImmToRam=1, RamNWE low, MAR=0x2000 -> RAM[0x2000]=0x9E and o_busOE=0. RamNOE and InstrNOE both low -> o_bus = RAM data and o_busConflict=1, staying 1 until reset.
- i_hlt=1 with all strobes low -> no register changes and o_ramWE=0. Reset asserted in the same cycle as RamNWE low -> no write, and all registers at their reset values after the edge.

Source files
------------

// File: rtl/mem_unit_if.sv
// Strobe, bus and RAM signal bundle between the control unit,
// the shared bus and mem_unit.
interface mem_unit_if;
    logic        i_hlt;
    logic        i_ctrlPCIncrN;
    logic        i_ctrlPCLoadN;
    logic        i_ctrlSPUp;
    logic        i_ctrlSPNEn;
    logic        i_ctrlInstrNWE;
    logic        i_ctrlInstrNOE;
    logic        i_ctrlMar0NWE;
    logic        i_ctrlMar1NWE;
    logic        i_ctrlInstrImmToRam;
    logic        i_ctrlRamNWE;
    logic        i_ctrlRamNOE;
    logic [7:0]  i_bus;
    logic [7:0]  o_bus;
    logic        o_busOE;
    logic        o_busConflict;
    logic [7:0]  o_instrCode;
    logic [15:0] o_pc;
    logic [15:0] o_ramAddr;
    logic [7:0]  o_ramWData;
    logic        o_ramWE;
    logic [7:0]  i_ramRData;

    modport slave (
        input  i_hlt, i_ctrlPCIncrN, i_ctrlPCLoadN, i_ctrlSPUp,
        input  i_ctrlSPNEn, i_ctrlInstrNWE, i_ctrlInstrNOE,
        input  i_ctrlMar0NWE, i_ctrlMar1NWE, i_ctrlInstrImmToRam,
        input  i_ctrlRamNWE, i_ctrlRamNOE, i_bus, i_ramRData,
        output o_bus, o_busOE, o_busConflict, o_instrCode,
        output o_pc, o_ramAddr, o_ramWData, o_ramWE
    );

    modport master (
        output i_hlt, i_ctrlPCIncrN, i_ctrlPCLoadN, i_ctrlSPUp,
        output i_ctrlSPNEn, i_ctrlInstrNWE, i_ctrlInstrNOE,
        output i_ctrlMar0NWE, i_ctrlMar1NWE, i_ctrlInstrImmToRam,
        output i_ctrlRamNWE, i_ctrlRamNOE, i_bus, i_ramRData,
        input  o_bus, o_busOE, o_busConflict, o_instrCode,
        input  o_pc, o_ramAddr, o_ramWData, o_ramWE
    );
endinterface

// File: rtl/mem_unit.sv
// Memory-side datapath: PC, SP, MAR, IR and arbitration of a
// single-port async-read byte RAM.
module mem_unit (
    input  logic      i_clk,
    input  logic      i_reset,
    mem_unit_if.slave bif
);
    logic [15:0] r_pc;
    logic [7:0]  r_sp;
    logic [7:0]  r_mar0;
    logic [7:0]  r_mar1;
    logic [15:0] r_ir;
    logic        r_conflict;

    logic [15:0] w_mar;
    logic [7:0]  w_spAddr;
    logic        w_ramWr;
    logic        w_ramRd;
    logic        w_immRd;

    assign w_mar    = {r_mar1, r_mar0};
    assign w_spAddr = bif.i_ctrlSPUp ? r_sp + 8'd1 : r_sp;
    assign w_ramWr  = ~bif.i_ctrlRamNWE;
    assign w_ramRd  = ~bif.i_ctrlRamNOE;
    assign w_immRd  = ~bif.i_ctrlInstrNOE;

    always_comb begin
        if (!bif.i_ctrlSPNEn)
            bif.o_ramAddr = {8'hFF, w_spAddr};
        else if (w_ramWr || w_ramRd)
            bif.o_ramAddr = w_mar;
        else
            bif.o_ramAddr = r_pc;
    end

    assign bif.o_ramWE = w_ramWr & ~bif.i_hlt & ~i_reset;
    assign bif.o_ramWData = bif.i_ctrlInstrImmToRam ? r_ir[7:0]
                                                    : bif.i_bus;

    // A write cycle owns the bus direction, so reads are suppressed.
    always_comb begin
        bif.o_busOE = 1'b0;
        bif.o_bus   = 8'h00;
        if (!i_reset && !w_ramWr) begin
            if (w_ramRd) begin
                bif.o_busOE = 1'b1;
                bif.o_bus   = bif.i_ramRData;
            end else if (w_immRd) begin
                bif.o_busOE = 1'b1;
                bif.o_bus   = r_ir[7:0];
            end
        end
    end

    assign bif.o_busConflict = r_conflict;
    assign bif.o_instrCode   = r_ir[15:8];
    assign bif.o_pc          = r_pc;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc       <= 16'h0000;
            r_sp       <= 8'hFF;
            r_mar0     <= 8'h00;
            r_mar1     <= 8'h00;
            r_ir       <= 16'h0000;
            r_conflict <= 1'b0;
        end else if (!bif.i_hlt) begin
            if (!bif.i_ctrlPCLoadN)
                r_pc <= w_mar;
            else if (!bif.i_ctrlPCIncrN)
                r_pc <= r_pc + 16'd1;
            if (!bif.i_ctrlSPNEn)
                r_sp <= bif.i_ctrlSPUp ? r_sp + 8'd1 : r_sp - 8'd1;
            if (!bif.i_ctrlMar0NWE)
                r_mar0 <= bif.i_bus;
            if (!bif.i_ctrlMar1NWE)
                r_mar1 <= bif.i_bus;
            if (!bif.i_ctrlInstrNWE)
                r_ir <= {r_ir[7:0], bif.i_ramRData};
            if (w_ramRd && w_immRd)
                r_conflict <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_unit.sv
// Randomized bench for mem_unit against a behavioural model with
// its own RAM image.
module tb_mem_unit;
    logic clk;
    logic reset;
    mem_unit_if bif ();

    mem_unit dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bif     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Bench RAM: unwritten bytes read as a fixed pattern.
    logic [7:0]  ram [0:65535];
    bit          wrt [0:65535];
    logic        poke_en = 1'b0;
    logic [15:0] poke_a = 16'h0;
    logic [7:0]  poke_d = 8'h0;

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        if (bif.o_ramWE) begin
            ram[bif.o_ramAddr] <= bif.o_ramWData;
            wrt[bif.o_ramAddr] <= 1'b1;
        end else if (poke_en) begin
            ram[poke_a] <= poke_d;
            wrt[poke_a] <= 1'b1;
        end
    end

    assign bif.i_ramRData = wrt[bif.o_ramAddr] ? ram[bif.o_ramAddr]
                                               : init_byte(bif.o_ramAddr);

    // Reference model state
    int m_pc, m_sp, m_mar0, m_mar1, m_ir;
    bit m_conf;
    int mm [0:65535];

    function automatic int exp_addr();
        if (!bif.i_ctrlSPNEn)
            return 'hFF00 + (bif.i_ctrlSPUp ? (m_sp + 1) % 256 : m_sp);
        if (!bif.i_ctrlRamNWE || !bif.i_ctrlRamNOE)
            return m_mar1 * 256 + m_mar0;
        return m_pc;
    endfunction

    function automatic int exp_bus();
        if (reset || !bif.i_ctrlRamNWE) return -1;
        if (!bif.i_ctrlRamNOE) return mm[exp_addr()];
        if (!bif.i_ctrlInstrNOE) return m_ir % 256;
        return -1;
    endfunction

    task automatic idle();
        reset = 1'b0;
        bif.i_hlt = 1'b0;
        bif.i_ctrlPCIncrN = 1'b1;
        bif.i_ctrlPCLoadN = 1'b1;
        bif.i_ctrlSPUp = 1'b0;
        bif.i_ctrlSPNEn = 1'b1;
        bif.i_ctrlInstrNWE = 1'b1;
        bif.i_ctrlInstrNOE = 1'b1;
        bif.i_ctrlMar0NWE = 1'b1;
        bif.i_ctrlMar1NWE = 1'b1;
        bif.i_ctrlInstrImmToRam = 1'b0;
        bif.i_ctrlRamNWE = 1'b1;
        bif.i_ctrlRamNOE = 1'b1;
        bif.i_bus = 8'h00;
    endtask

    // Advance one clock, updating the model from the driven strobes.
    task automatic step();
        int a, rd, n_pc, n_sp, n_m0, n_m1, n_ir, wd;
        bit n_conf, wr;
        a = exp_addr();
        rd = mm[a];
        n_pc = m_pc; n_sp = m_sp; n_m0 = m_mar0; n_m1 = m_mar1;
        n_ir = m_ir; n_conf = m_conf; wr = 0; wd = 0;
        if (reset) begin
            n_pc = 0; n_sp = 255; n_m0 = 0; n_m1 = 0; n_ir = 0; n_conf = 0;
        end else if (!bif.i_hlt) begin
            if (!bif.i_ctrlRamNWE) begin
                wr = 1;
                wd = bif.i_ctrlInstrImmToRam ? m_ir % 256 : int'(bif.i_bus);
            end
            if (!bif.i_ctrlRamNOE && !bif.i_ctrlInstrNOE) n_conf = 1;
            if (!bif.i_ctrlPCLoadN) n_pc = m_mar1 * 256 + m_mar0;
            else if (!bif.i_ctrlPCIncrN) n_pc = (m_pc + 1) % 65536;
            if (!bif.i_ctrlSPNEn)
                n_sp = bif.i_ctrlSPUp ? (m_sp + 1) % 256 : (m_sp + 255) % 256;
            if (!bif.i_ctrlMar0NWE) n_m0 = bif.i_bus;
            if (!bif.i_ctrlMar1NWE) n_m1 = bif.i_bus;
            if (!bif.i_ctrlInstrNWE) n_ir = (m_ir % 256) * 256 + rd;
        end
        @(posedge clk);
        m_pc = n_pc; m_sp = n_sp; m_mar0 = n_m0; m_mar1 = n_m1;
        m_ir = n_ir; m_conf = n_conf;
        if (wr) mm[a] = wd;
        @(negedge clk);
    endtask

    task automatic poke(input int a, input int d);
        idle();
        poke_en = 1'b1; poke_a = 16'(a); poke_d = 8'(d);
        mm[a] = d;
        step();
        poke_en = 1'b0;
    endtask

    task automatic set_mar(input int a);
        idle(); bif.i_ctrlMar0NWE = 1'b0; bif.i_bus = 8'(a % 256); step();
        idle(); bif.i_ctrlMar1NWE = 1'b0; bif.i_bus = 8'(a / 256); step();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1; bif.i_hlt = 1'b1;
        bif.i_ctrlRamNWE = 1'b0; bif.i_ctrlRamNOE = 1'b0;
        bif.i_ctrlInstrNOE = 1'b0;
        #1;
        checks++; if (bif.o_ramWE !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", bif.o_ramWE); end
        checks++; if (bif.o_busOE !== 1'b0) begin failures++; $display("FAIL rst_oe got=%b exp=0", bif.o_busOE); end
        step(); step();
        idle(); bif.i_ctrlInstrNOE = 1'b0; #1;
        checks++; if (bif.o_pc !== 16'h0000) begin failures++; $display("FAIL rst_pc got=%h exp=0000", bif.o_pc); end
        checks++; if (bif.o_instrCode !== 8'h00) begin failures++; $display("FAIL rst_ir got=%h exp=00", bif.o_instrCode); end
        checks++; if (bif.o_busConflict !== 1'b0) begin failures++; $display("FAIL rst_conf got=%b exp=0", bif.o_busConflict); end
        checks++; if (bif.o_bus !== 8'h00 || bif.o_busOE !== 1'b1) begin failures++; $display("FAIL rst_irlo got=%h/%b exp=00/1", bif.o_bus, bif.o_busOE); end
        step();
    endtask

    task automatic test_fetch();
        poke(0, 'h3A);
        poke(1, 'h7C);
        for (int i = 0; i < 2; i++) begin
            idle(); bif.i_ctrlInstrNWE = 1'b0; bif.i_ctrlPCIncrN = 1'b0; #1;
            checks++; if (bif.o_ramAddr !== 16'(i)) begin failures++; $display("FAIL fetch_addr got=%h exp=%h", bif.o_ramAddr, i); end
            step();
        end
        idle(); bif.i_ctrlInstrNOE = 1'b0; #1;
        checks++; if (bif.o_instrCode !== 8'h3A) begin failures++; $display("FAIL fetch_op got=%h exp=3a", bif.o_instrCode); end
        checks++; if (bif.o_pc !== 16'h0002) begin failures++; $display("FAIL fetch_pc got=%h exp=0002", bif.o_pc); end
        checks++; if (bif.o_bus !== 8'h7C) begin failures++; $display("FAIL fetch_imm got=%h exp=7c", bif.o_bus); end
        step();
    endtask

    task automatic test_pc_load();
        set_mar('h1234);
        idle(); bif.i_ctrlPCLoadN = 1'b0; bif.i_ctrlPCIncrN = 1'b0; step();
        checks++; if (bif.o_pc !== 16'h1234) begin failures++; $display("FAIL pc_load got=%h exp=1234", bif.o_pc); end
        set_mar('hFFFF);
        idle(); bif.i_ctrlPCLoadN = 1'b0; step();
        checks++; if (bif.o_pc !== 16'hFFFF) begin failures++; $display("FAIL pc_max got=%h exp=ffff", bif.o_pc); end
        idle(); bif.i_ctrlPCIncrN = 1'b0; step();
        checks++; if (bif.o_pc !== 16'h0000) begin failures++; $display("FAIL pc_wrap got=%h exp=0000", bif.o_pc); end
    endtask

    task automatic test_stack();
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        idle(); bif.i_ctrlSPNEn = 1'b0; bif.i_ctrlRamNWE = 1'b0; bif.i_bus = 8'h55; #1;
        checks++; if (bif.o_ramAddr !== 16'hFFFF) begin failures++; $display("FAIL push_addr got=%h exp=ffff", bif.o_ramAddr); end
        checks++; if (bif.o_ramWE !== 1'b1 || bif.o_ramWData !== 8'h55) begin failures++; $display("FAIL push_we got=%b/%h exp=1/55", bif.o_ramWE, bif.o_ramWData); end
        step();
        idle(); bif.i_ctrlSPNEn = 1'b0; bif.i_ctrlSPUp = 1'b1; bif.i_ctrlRamNOE = 1'b0; #1;
        checks++; if (bif.o_ramAddr !== 16'hFFFF) begin failures++; $display("FAIL pop_addr got=%h exp=ffff", bif.o_ramAddr); end
        checks++; if (bif.o_bus !== 8'h55 || bif.o_busOE !== 1'b1) begin failures++; $display("FAIL pop_data got=%h/%b exp=55/1", bif.o_bus, bif.o_busOE); end
        step();
        idle(); bif.i_ctrlSPNEn = 1'b0; bif.i_ctrlSPUp = 1'b1; bif.i_ctrlRamNOE = 1'b0; #1;
        checks++; if (bif.o_ramAddr !== 16'hFF00) begin failures++; $display("FAIL pop_wrap got=%h exp=ff00", bif.o_ramAddr); end
        step();
        idle(); bif.i_ctrlSPNEn = 1'b0; bif.i_ctrlRamNWE = 1'b0; bif.i_bus = v; #1;
        checks++; if (bif.o_ramAddr !== 16'hFF00) begin failures++; $display("FAIL push00_addr got=%h exp=ff00", bif.o_ramAddr); end
        step();
        idle(); bif.i_ctrlSPNEn = 1'b0; bif.i_ctrlSPUp = 1'b1; bif.i_ctrlRamNOE = 1'b0; #1;
        checks++; if (bif.o_ramAddr !== 16'hFF00 || bif.o_bus !== v) begin failures++; $display("FAIL pop00 got=%h/%h exp=ff00/%h", bif.o_ramAddr, bif.o_bus, v); end
        step();
        idle(); bif.i_ctrlSPNEn = 1'b0; #1;
        checks++; if (bif.o_ramAddr !== 16'hFF00) begin failures++; $display("FAIL sp00 got=%h exp=ff00", bif.o_ramAddr); end
        step();
        idle(); bif.i_ctrlSPNEn = 1'b0; bif.i_ctrlSPUp = 1'b1; step();
    endtask

    task automatic test_imm_write();
        poke(m_pc, 'h9E);
        idle(); bif.i_ctrlInstrNWE = 1'b0; step();
        set_mar('h2000);
        idle(); bif.i_ctrlInstrImmToRam = 1'b1; bif.i_ctrlRamNWE = 1'b0;
        bif.i_ctrlRamNOE = 1'b0; bif.i_bus = 8'h11; #1;
        checks++; if (bif.o_ramAddr !== 16'h2000) begin failures++; $display("FAIL imm_addr got=%h exp=2000", bif.o_ramAddr); end
        checks++; if (bif.o_ramWData !== 8'h9E || bif.o_ramWE !== 1'b1) begin failures++; $display("FAIL imm_wdata got=%h/%b exp=9e/1", bif.o_ramWData, bif.o_ramWE); end
        checks++; if (bif.o_busOE !== 1'b0) begin failures++; $display("FAIL imm_oe got=%b exp=0", bif.o_busOE); end
        step();
        idle(); bif.i_ctrlRamNOE = 1'b0; #1;
        checks++; if (bif.o_bus !== 8'h9E) begin failures++; $display("FAIL imm_rd got=%h exp=9e", bif.o_bus); end
        step();
        poke('h2001, 'h61);
        idle(); bif.i_ctrlMar0NWE = 1'b0; bif.i_bus = 8'h01; step();
        idle(); bif.i_ctrlRamNOE = 1'b0; bif.i_ctrlInstrNOE = 1'b0; #1;
        checks++; if (bif.o_bus !== 8'h61 || bif.o_busOE !== 1'b1) begin failures++; $display("FAIL conf_bus got=%h/%b exp=61/1", bif.o_bus, bif.o_busOE); end
        step();
        for (int i = 0; i < 3; i++) begin
            idle(); step();
            checks++; if (bif.o_busConflict !== 1'b1) begin failures++; $display("FAIL conf_sticky got=%b exp=1", bif.o_busConflict); end
        end
    endtask

    task automatic test_hlt();
        int pc0, ir0, mar0;
        pc0 = m_pc; ir0 = m_ir; mar0 = m_mar1 * 256 + m_mar0;
        idle(); bif.i_hlt = 1'b1;
        bif.i_ctrlPCIncrN = 1'b0; bif.i_ctrlPCLoadN = 1'b0; bif.i_ctrlSPNEn = 1'b0;
        bif.i_ctrlInstrNWE = 1'b0; bif.i_ctrlMar0NWE = 1'b0; bif.i_ctrlMar1NWE = 1'b0;
        bif.i_ctrlRamNWE = 1'b0; bif.i_bus = 8'($urandom_range(0, 255)); #1;
        checks++; if (bif.o_ramWE !== 1'b0) begin failures++; $display("FAIL hlt_we got=%b exp=0", bif.o_ramWE); end
        step();
        idle(); bif.i_ctrlRamNOE = 1'b0; #1;
        checks++; if (bif.o_pc !== 16'(pc0)) begin failures++; $display("FAIL hlt_pc got=%h exp=%h", bif.o_pc, pc0); end
        checks++; if (bif.o_instrCode !== 8'(ir0 / 256)) begin failures++; $display("FAIL hlt_ir got=%h exp=%h", bif.o_instrCode, ir0 / 256); end
        checks++; if (bif.o_ramAddr !== 16'(mar0)) begin failures++; $display("FAIL hlt_mar got=%h exp=%h", bif.o_ramAddr, mar0); end
        step();
    endtask

    task automatic test_reset_write();
        set_mar('h3000);
        idle(); reset = 1'b1; bif.i_ctrlRamNWE = 1'b0; bif.i_bus = 8'hA5; #1;
        checks++; if (bif.o_ramWE !== 1'b0) begin failures++; $display("FAIL rstwr_we got=%b exp=0", bif.o_ramWE); end
        step();
        idle(); bif.i_ctrlRamNOE = 1'b0; #1;
        checks++; if (bif.o_pc !== 16'h0 || bif.o_instrCode !== 8'h0 || bif.o_busConflict !== 1'b0) begin failures++; $display("FAIL rstwr_regs got=%h/%h/%b exp=0000/00/0", bif.o_pc, bif.o_instrCode, bif.o_busConflict); end
        checks++; if (bif.o_ramAddr !== 16'h0000) begin failures++; $display("FAIL rstwr_mar got=%h exp=0000", bif.o_ramAddr); end
        step();
        idle(); bif.i_ctrlSPNEn = 1'b0; #1;
        checks++; if (bif.o_ramAddr !== 16'hFFFF) begin failures++; $display("FAIL rstwr_sp got=%h exp=ffff", bif.o_ramAddr); end
        step();
        idle(); bif.i_ctrlSPNEn = 1'b0; bif.i_ctrlSPUp = 1'b1; step();
        set_mar('h3000);
        idle(); bif.i_ctrlRamNOE = 1'b0; #1;
        checks++; if (bif.o_bus !== 8'h6A) begin failures++; $display("FAIL rstwr_mem got=%h exp=6a", bif.o_bus); end
        step();
    endtask

    task automatic test_random();
        int eb;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            bif.i_hlt = ($urandom_range(0, 7) == 0);
            bif.i_ctrlPCIncrN = ($urandom_range(0, 2) != 0);
            bif.i_ctrlPCLoadN = ($urandom_range(0, 5) != 0);
            bif.i_ctrlSPUp = 1'($urandom_range(0, 1));
            bif.i_ctrlSPNEn = ($urandom_range(0, 2) != 0);
            bif.i_ctrlInstrNWE = ($urandom_range(0, 2) != 0);
            bif.i_ctrlInstrNOE = ($urandom_range(0, 2) != 0);
            bif.i_ctrlMar0NWE = ($urandom_range(0, 2) != 0);
            bif.i_ctrlMar1NWE = ($urandom_range(0, 2) != 0);
            bif.i_ctrlInstrImmToRam = 1'($urandom_range(0, 1));
            bif.i_ctrlRamNWE = ($urandom_range(0, 2) != 0);
            bif.i_ctrlRamNOE = ($urandom_range(0, 2) != 0);
            bif.i_bus = 8'($urandom_range(0, 255));
            #1;
            eb = exp_bus();
            checks++; if (bif.o_ramAddr !== 16'(exp_addr())) begin failures++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, bif.o_ramAddr, exp_addr()); end
            checks++; if (bif.o_ramWE !== (!bif.i_ctrlRamNWE && !bif.i_hlt && !reset)) begin failures++; $display("FAIL rnd_we n=%0d got=%b", n, bif.o_ramWE); end
            checks++; if (bif.o_ramWData !== (bif.i_ctrlInstrImmToRam ? 8'(m_ir % 256) : bif.i_bus)) begin failures++; $display("FAIL rnd_wdata n=%0d got=%h", n, bif.o_ramWData); end
            checks++; if (bif.o_busOE !== (eb >= 0) || bif.o_bus !== (eb >= 0 ? 8'(eb) : 8'h00)) begin failures++; $display("FAIL rnd_bus n=%0d got=%h/%b exp=%0d", n, bif.o_bus, bif.o_busOE, eb); end
            step();
            checks++; if (bif.o_pc !== 16'(m_pc) || bif.o_instrCode !== 8'(m_ir / 256) || bif.o_busConflict !== m_conf) begin failures++; $display("FAIL rnd_regs n=%0d got=%h/%h/%b exp=%h/%h/%b", n, bif.o_pc, bif.o_instrCode, bif.o_busConflict, m_pc, m_ir / 256, m_conf); end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mm[i] = int'(init_byte(16'(i)));
        m_pc = 0; m_sp = 255; m_mar0 = 0; m_mar1 = 0; m_ir = 0; m_conf = 0;
        idle();
        @(negedge clk);
        test_reset();
        test_fetch();
        test_pc_load();
        test_stack();
        test_imm_write();
        test_hlt();
        test_reset_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
